// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding and default sizes.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'b00,
    PC_SEL_BR  = 2'b01,
    PC_SEL_JMP = 2'b10,
    PC_SEL_JR  = 2'b11
  } pc_sel_e;

  localparam int DEF_PC_WIDTH    = 32;
  localparam int DEF_IMM_WIDTH   = 16;
  localparam int DEF_JADDR_WIDTH = 26;
  localparam int DEF_RAS_DEPTH   = 8;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: top pointer plus occupancy count, sticky overflow/underflow flag.
module pc_ras #(
  parameter int PC_WIDTH  = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                PUSH,
  input  logic                POP,
  input  logic [PC_WIDTH-1:0] WDATA,
  output logic [PC_WIDTH-1:0] TOP,
  output logic                EMPTY,
  output logic                FULL,
  output logic                ERR
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W:0]      r_count;
  logic                r_err;
  logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];

  logic                w_empty;
  logic                w_full;
  logic                w_replace;
  logic                w_push;
  logic                w_wr;
  logic [PTR_W-1:0]    w_waddr;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (PTR_W+1)'(RAS_DEPTH));
  // Simultaneous push/pop on a non-empty stack swaps the top in place.
  assign w_replace = EN && PUSH && POP && !w_empty;
  assign w_push    = EN && PUSH && !w_replace;
  assign w_wr      = w_replace || w_push;
  assign w_waddr   = w_replace ? r_ptr : r_ptr + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_push) begin
      r_ptr <= r_ptr + 1'b1;
      if (!w_full) r_count <= r_count + 1'b1;
      if (w_full || POP) r_err <= 1'b1;
    end else if (EN && POP && !PUSH) begin
      if (w_empty) begin
        r_err <= 1'b1;
      end else begin
        r_ptr   <= r_ptr - 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // NOTE: entry storage has no reset; contents only matter once the count says they are valid.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[w_waddr] <= WDATA;
  end

  assign TOP   = r_mem[r_ptr];
  assign EMPTY = w_empty;
  assign FULL  = w_full;
  assign ERR   = r_err;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: holds PC, selects sequential/branch/jump/register/return targets.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                     PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                     IMM_WIDTH   = DEF_IMM_WIDTH,
  parameter int                     JADDR_WIDTH = DEF_JADDR_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = 32'h0000_1000,
  parameter int                     RAS_DEPTH   = DEF_RAS_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PC_LOAD,
  input  logic [1:0]             PC_SEL,
  input  logic                   BR_TAKEN,
  input  logic [IMM_WIDTH-1:0]   IMM,
  input  logic [JADDR_WIDTH-1:0] JADDR,
  input  logic [PC_WIDTH-1:0]    RJ_ADDR,
  input  logic                   PUSH,
  input  logic                   POP,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [PC_WIDTH-1:0]    PC_PLUS_ONE,
  output logic                   RAS_EMPTY,
  output logic                   RAS_FULL,
  output logic                   RAS_ERR
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_plus_one;
  logic [PC_WIDTH-1:0] w_br_target;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_ras_empty;

  assign w_pc_plus_one = r_pc + 1'b1;
  assign w_br_target   = w_pc_plus_one + {{(PC_WIDTH-IMM_WIDTH){IMM[IMM_WIDTH-1]}}, IMM};

  // NOTE: every path assigns w_next_pc via the leading default, so no latch is inferred.
  always_comb begin
    w_next_pc = w_pc_plus_one;
    if (POP && !w_ras_empty) begin
      w_next_pc = w_ras_top;
    end else begin
      unique case (pc_sel_e'(PC_SEL))
        PC_SEL_SEQ: w_next_pc = w_pc_plus_one;
        PC_SEL_BR:  w_next_pc = BR_TAKEN ? w_br_target : w_pc_plus_one;
        PC_SEL_JMP: w_next_pc = {{(PC_WIDTH-JADDR_WIDTH){1'b0}}, JADDR};
        PC_SEL_JR:  w_next_pc = RJ_ADDR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST)          r_pc <= RESET_PC;
    else if (PC_LOAD) r_pc <= w_next_pc;
  end

  pc_ras #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (PC_LOAD),
    .PUSH  (PUSH),
    .POP   (POP),
    .WDATA (w_pc_plus_one),
    .TOP   (w_ras_top),
    .EMPTY (w_ras_empty),
    .FULL  (RAS_FULL),
    .ERR   (RAS_ERR)
  );

  assign PC          = r_pc;
  assign PC_PLUS_ONE = w_pc_plus_one;
  assign RAS_EMPTY   = w_ras_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, branches, jumps, RAS push/pop/overflow, stall, wrap.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PC_LOAD;
  logic [1:0]  PC_SEL;
  logic        BR_TAKEN;
  logic [15:0] IMM;
  logic [25:0] JADDR;
  logic [31:0] RJ_ADDR;
  logic        PUSH;
  logic        POP;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_ONE;
  logic        RAS_EMPTY;
  logic        RAS_FULL;
  logic        RAS_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .PC_LOAD     (PC_LOAD),
    .PC_SEL      (PC_SEL),
    .BR_TAKEN    (BR_TAKEN),
    .IMM         (IMM),
    .JADDR       (JADDR),
    .RJ_ADDR     (RJ_ADDR),
    .PUSH        (PUSH),
    .POP         (POP),
    .PC          (PC),
    .PC_PLUS_ONE (PC_PLUS_ONE),
    .RAS_EMPTY   (RAS_EMPTY),
    .RAS_FULL    (RAS_FULL),
    .RAS_ERR     (RAS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle();
    RST = 1'b0; PC_LOAD = 1'b1; PC_SEL = 2'b00; BR_TAKEN = 1'b0;
    IMM = '0; JADDR = '0; RJ_ADDR = '0; PUSH = 1'b0; POP = 1'b0;
  endtask

  // Apply current inputs across one rising edge, then sample 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    tick();
    idle();
  endtask

  task automatic jump_reg(input logic [31:0] addr);
    idle(); PC_SEL = 2'b11; RJ_ADDR = addr; tick(); idle();
  endtask

  initial begin
    idle();
    @(negedge CLK);

    // 1: reset and sequential stepping
    do_reset();
    check("rst_pc", PC, 32'h1000);
    check("rst_empty", 32'(RAS_EMPTY), 32'd1);
    check("rst_full", 32'(RAS_FULL), 32'd0);
    check("rst_err", 32'(RAS_ERR), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", PC, 32'h1000 + 32'(i));
    end
    check("seq_empty", 32'(RAS_EMPTY), 32'd1);

    // 2: branch taken backwards, then not taken
    PC_SEL = 2'b01; BR_TAKEN = 1'b1; IMM = 16'hFFFC; tick();
    check("br_taken", PC, 32'h1000);
    jump_reg(32'h1003);
    PC_SEL = 2'b01; BR_TAKEN = 1'b0; IMM = 16'hFFFC; tick();
    check("br_not_taken", PC, 32'h1004);
    PC_SEL = 2'b01; BR_TAKEN = 1'b1; IMM = 16'h0010; tick();
    check("br_fwd", PC, 32'h1015);
    idle();

    // 3: call via absolute jump, then return
    jump_reg(32'h2000);
    check("jr_pc", PC, 32'h2000);
    PC_SEL = 2'b10; JADDR = 26'h0000040; PUSH = 1'b1; tick(); idle();
    check("jal_pc", PC, 32'h40);
    check("jal_not_empty", 32'(RAS_EMPTY), 32'd0);
    POP = 1'b1; tick(); idle();
    check("ret_pc", PC, 32'h2001);
    check("ret_empty", 32'(RAS_EMPTY), 32'd1);
    check("ret_err", 32'(RAS_ERR), 32'd0);

    // 3b: push+pop same cycle swaps top; push+pop on empty acts as push and flags error
    do_reset();
    PUSH = 1'b1; tick(); idle();
    check("pp_push_pc", PC, 32'h1001);
    PUSH = 1'b1; POP = 1'b1; tick(); idle();
    check("pp_swap_pc", PC, 32'h1001);
    check("pp_swap_err", 32'(RAS_ERR), 32'd0);
    POP = 1'b1; tick(); idle();
    check("pp_pop_new_top", PC, 32'h1002);
    check("pp_pop_empty", 32'(RAS_EMPTY), 32'd1);
    PUSH = 1'b1; POP = 1'b1; PC_SEL = 2'b11; RJ_ADDR = 32'h0500; tick(); idle();
    check("pp_empty_pc", PC, 32'h0500);
    check("pp_empty_err", 32'(RAS_ERR), 32'd1);
    check("pp_empty_pushed", 32'(RAS_EMPTY), 32'd0);
    POP = 1'b1; tick(); idle();
    check("pp_empty_ret", PC, 32'h1003);

    // 4: overflow with 9 pushes, drain 8, underflow
    do_reset();
    for (int i = 0; i < 9; i++) begin
      PUSH = 1'b1; tick();
      if (i == 7) begin
        check("ovf_full8", 32'(RAS_FULL), 32'd1);
        check("ovf_err8", 32'(RAS_ERR), 32'd0);
      end
    end
    idle();
    check("ovf_pc", PC, 32'h1009);
    check("ovf_full", 32'(RAS_FULL), 32'd1);
    check("ovf_err", 32'(RAS_ERR), 32'd1);
    for (int j = 0; j < 8; j++) begin
      POP = 1'b1; tick();
      check("ovf_pop", PC, 32'h1009 - 32'(j));
    end
    idle();
    check("drain_empty", 32'(RAS_EMPTY), 32'd1);
    check("drain_full", 32'(RAS_FULL), 32'd0);
    POP = 1'b1; tick(); idle();
    check("unf_pc", PC, 32'h1003);
    check("unf_err", 32'(RAS_ERR), 32'd1);

    // 5: stall, wrap, reset mid-sequence
    do_reset();
    PC_LOAD = 1'b0; PC_SEL = 2'b11; RJ_ADDR = 32'hDEAD; PUSH = 1'b1; tick();
    tick(); idle();
    check("stall_pc", PC, 32'h1000);
    check("stall_empty", 32'(RAS_EMPTY), 32'd1);
    check("stall_err", 32'(RAS_ERR), 32'd0);
    jump_reg(32'hFFFF_FFFF);
    check("wrap_plus_one", PC_PLUS_ONE, 32'h0);
    tick();
    check("wrap_pc", PC, 32'h0);
    PUSH = 1'b1; tick(); tick(); idle();
    check("pre_rst_empty", 32'(RAS_EMPTY), 32'd0);
    RST = 1'b1; PUSH = 1'b1; PC_SEL = 2'b11; RJ_ADDR = 32'h7777; tick(); idle();
    check("mid_rst_pc", PC, 32'h1000);
    check("mid_rst_empty", 32'(RAS_EMPTY), 32'd1);
    check("mid_rst_err", 32'(RAS_ERR), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
